// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller: FSM state encoding and default depth.
package mem_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StWrite,
      StResp
   } state_e;

   localparam int unsigned MemDepthDefault = 4096;

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-request memory access controller bridging a valid/ready pipeline port to a simple memory.
// Optional address bounds checking is enabled by defining MEM_ACCESS_CTRL_BOUNDS_CHECK_EN.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_DEPTH = MemDepthDefault
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e              state_q;
   logic                req_ready_q;
   logic                resp_valid_q;
   logic                resp_err_q;
   logic [DATA_W-1:0]   resp_rdata_q;
   logic [DATA_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic                mem_wr_q;
   logic                mem_rd_q;
   logic                oob;

   always_comb begin
      oob = 1'b0;
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
      oob = (req_addr >= DATA_W'(MEM_DEPTH));
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wr_q     <= 1'b0;
         mem_rd_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  req_ready_q <= 1'b0;
                  mem_addr_q  <= req_addr;
                  mem_wdata_q <= req_wdata;
                  resp_err_q  <= 1'b0;
                  // Out-of-range requests skip the memory entirely and answer with an error.
                  if (oob) begin
                     state_q      <= StResp;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                  end else if (req_wr) begin
                     state_q  <= StWrite;
                     mem_wr_q <= 1'b1;
                  end else begin
                     state_q  <= StRead;
                     mem_rd_q <= 1'b1;
                  end
               end
            end
            StRead: begin
               resp_rdata_q <= mem_rdata;
               mem_rd_q     <= 1'b0;
               resp_valid_q <= 1'b1;
               state_q      <= StResp;
            end
            StWrite: begin
               resp_rdata_q <= '0;
               mem_wr_q     <= 1'b0;
               resp_valid_q <= 1'b1;
               state_q      <= StResp;
            end
            StResp: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  resp_err_q   <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= StIdle;
               end
            end
            default: begin
               state_q     <= StIdle;
               req_ready_q <= 1'b1;
               mem_wr_q    <= 1'b0;
               mem_rd_q    <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wr     = mem_wr_q;
   assign mem_rd     = mem_rd_q;
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
   assign resp_err   = resp_err_q;
`else
   assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a behavioural word memory.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr;
   logic        mem_rd;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:8191];

   int passed;
   int total;
   int cyc;
   int rd_cnt;
   int wr_cnt;
   int both_cnt;
   logic [31:0] resp_q[$];

   mem_access_ctrl #(
      .DATA_W   (32),
      .MEM_DEPTH(4096)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wr    (mem_wr),
      .mem_rd    (mem_rd),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem_rd ? mem[mem_addr[12:0]] : 32'h0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_wr) mem[mem_addr[12:0]] <= mem_wdata;
      if (mem_rd) rd_cnt <= rd_cnt + 1;
      if (mem_wr) wr_cnt <= wr_cnt + 1;
      if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
      if (rst_n && resp_valid && resp_ready) resp_q.push_back(resp_rdata);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!req_ready && n < 10) begin
         tick();
         n++;
      end
      if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'h1);
   endtask

   initial begin
      int acc0;
      int acc1;
      int acc2;
      passed   = 0;
      total    = 0;
      cyc      = 0;
      rd_cnt   = 0;
      wr_cnt   = 0;
      both_cnt = 0;
      for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_wr     = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b0;
      tick();
      tick();
      check("rst_req_ready", 32'(req_ready), 32'h1);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_resp_err", 32'(resp_err), 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_mem_rd", 32'(mem_rd), 32'h0);
      check("rst_mem_wr", 32'(mem_wr), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      rst_n = 1'b1;
      tick();

      // Store 0xDEADBEEF to word 5.
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'd5; req_wdata = 32'hDEADBEEF;
      tick();
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
      check("st_mem_wr", 32'(mem_wr), 32'h1);
      check("st_mem_rd", 32'(mem_rd), 32'h0);
      check("st_mem_addr", mem_addr, 32'd5);
      check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
      check("st_req_ready", 32'(req_ready), 32'h0);
      check("st_resp_early", 32'(resp_valid), 32'h0);
      tick();
      check("st_mem_wr_off", 32'(mem_wr), 32'h0);
      check("st_resp_valid", 32'(resp_valid), 32'h1);
      check("st_resp_rdata", resp_rdata, 32'h0);
      check("st_resp_err", 32'(resp_err), 32'h0);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("st_resp_done", 32'(resp_valid), 32'h0);
      check("st_back_idle", 32'(req_ready), 32'h1);
      check("st_wr_count", 32'(wr_cnt), 32'd1);

      // Load word 5 with 4 cycles of response backpressure.
      rd_cnt = 0;
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'd5;
      tick();
      req_valid = 1'b0;
      check("ld_mem_rd", 32'(mem_rd), 32'h1);
      check("ld_mem_wr", 32'(mem_wr), 32'h0);
      check("ld_mem_addr", mem_addr, 32'd5);
      tick();
      check("ld_mem_rd_off", 32'(mem_rd), 32'h0);
      check("ld_resp_valid", 32'(resp_valid), 32'h1);
      check("ld_resp_rdata", resp_rdata, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'd6;
         tick();
         check("bp_resp_valid", 32'(resp_valid), 32'h1);
         check("bp_resp_rdata", resp_rdata, 32'hDEADBEEF);
         check("bp_req_ready", 32'(req_ready), 32'h0);
      end
      req_valid = 1'b0;
      check("bp_rd_count", 32'(rd_cnt), 32'd1);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("bp_resp_done", 32'(resp_valid), 32'h0);
      check("bp_no_extra_wr", 32'(wr_cnt), 32'd1);

      // Address at the memory depth boundary.
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'd4096; req_wdata = 32'h0000_1234;
      tick();
      req_valid = 1'b0;
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
      check("oob_no_strobe", 32'(mem_wr), 32'h0);
      check("oob_resp_valid", 32'(resp_valid), 32'h1);
      check("oob_resp_err", 32'(resp_err), 32'h1);
      check("oob_resp_rdata", resp_rdata, 32'h0);
      resp_ready = 1'b1;
      tick();
`else
      check("oob_strobe", 32'(mem_wr), 32'h1);
      check("oob_addr", mem_addr, 32'd4096);
      tick();
      check("oob_resp_valid", 32'(resp_valid), 32'h1);
      check("oob_resp_err", 32'(resp_err), 32'h0);
      resp_ready = 1'b1;
      tick();
`endif
      resp_ready = 1'b0;
      check("oob_done", 32'(resp_valid), 32'h0);

      // Reset lands on the write strobe cycle.
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'd7; req_wdata = 32'h55;
      tick();
      req_valid = 1'b0;
      check("rw_strobe", 32'(mem_wr), 32'h1);
      rst_n = 1'b0;
      tick();
      check("rw_mem_wr", 32'(mem_wr), 32'h0);
      check("rw_resp_valid", 32'(resp_valid), 32'h0);
      check("rw_req_ready", 32'(req_ready), 32'h1);
      rst_n = 1'b1;
      tick();
      check("rw_stays_quiet", 32'(resp_valid), 32'h0);

      // Back-to-back: store 9, load 9, load 5 with req_valid held high.
      resp_q.delete();
      resp_ready = 1'b1;
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'd9; req_wdata = 32'hA5A5_5A5A;
      wait_ready();
      tick();
      acc0 = cyc;
      req_wr = 1'b0; req_addr = 32'd9; req_wdata = 32'h0;
      wait_ready();
      tick();
      acc1 = cyc;
      req_addr = 32'd5;
      wait_ready();
      tick();
      acc2 = cyc;
      req_valid = 1'b0;
      tick();
      tick();
      tick();
      check("b2b_gap1", 32'(acc1 - acc0), 32'd3);
      check("b2b_gap2", 32'(acc2 - acc1), 32'd3);
      check("b2b_resp_count", 32'(resp_q.size()), 32'd3);
      if (resp_q.size() == 3) begin
         check("b2b_resp0", resp_q[0], 32'h0);
         check("b2b_resp1", resp_q[1], 32'hA5A5_5A5A);
         check("b2b_resp2", resp_q[2], 32'hDEADBEEF);
      end
      check("never_rd_and_wr", 32'(both_cnt), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of data words and addresses.
REQ-002 SHALL have parameter MEM_DEPTH, default 4096, meaning the number of words in the attached data memory.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: a pipeline access request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the controller accepts a request this cycle.
REQ-007 SHALL have port req_wr, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, DATA_W bits: the word address.
REQ-009 SHALL have port req_wdata, input, DATA_W bits: the store data.
REQ-010 SHALL have port resp_valid, output, 1 bit: a response is present.
REQ-011 SHALL have port resp_ready, input, 1 bit: the pipeline takes the response.
REQ-012 SHALL have port resp_rdata, output, DATA_W bits: the load data (0 for stores).
REQ-013 SHALL have port resp_err, output, 1 bit: the access was rejected.
REQ-014 SHALL have memory-side ports mem_addr (output, DATA_W), mem_wdata (output, DATA_W), mem_wr (output, 1), mem_rd (output, 1) and mem_rdata (input, DATA_W). Memory timing on these ports: the write commits on the clk edge while mem_wr=1; the read is combinational while mem_rd=1.

Function
REQ-015 SHALL implement the FSM states IDLE, READ, WRITE and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE.
REQ-017 SHALL accept a request when req_valid and req_ready are both 1, register addr, wdata and wr, and move to WRITE if wr=1, otherwise to READ.
REQ-018 SHALL, in READ, drive mem_rd=1 and mem_addr=the registered addr for exactly one cycle, capture mem_rdata into resp_rdata at the end of that cycle, and move to RESP.
REQ-019 SHALL, in WRITE, drive mem_wr=1, mem_addr=addr and mem_wdata=wdata for exactly one cycle, set resp_rdata=0, and move to RESP.
REQ-020 SHALL, in RESP, hold resp_valid=1 with stable resp_rdata and resp_err until resp_ready=1, then return to IDLE.
REQ-021 SHALL give this latency: accept at edge N, memory strobe during cycle N+1, resp_valid=1 from edge N+2; minimum 3 cycles per access.
REQ-022 SHALL never assert mem_rd and mem_wr together, and SHALL hold both at 0 outside READ and WRITE.
REQ-023 SHALL ignore req_valid outside IDLE; a request arriving in the RESP cycle where resp_ready=1 is accepted only in the following IDLE cycle.
REQ-024 SHALL drive mem_addr and mem_wdata from registers only, with no combinational path from req_* to mem_*.

Reset
REQ-025 SHALL, while rst_n=0 at a clk edge, enter IDLE with resp_valid=0, resp_err=0, resp_rdata=0, mem_rd=0, mem_wr=0, mem_addr=0 and mem_wdata=0.
REQ-026 SHALL, on reset in READ, WRITE or RESP, drop the in-flight access; a WRITE cycle coinciding with the reset edge has its strobe deasserted from that edge.

Configuration
REQ-027 SHALL, with macro MEM_ACCESS_CTRL_BOUNDS_CHECK_EN defined, route an accepted request with addr >= MEM_DEPTH directly to RESP with resp_err=1, resp_rdata=0 and no mem_rd or mem_wr strobe.
REQ-028 SHALL, without MEM_ACCESS_CTRL_BOUNDS_CHECK_EN, tie resp_err to 0 and pass every address to memory unchecked.

Structure
REQ-029 SHALL take the FSM state enum and the MEM_DEPTH default from a shared package, mem_pkg.
REQ-030 SHALL be a single module with no sub-modules.

Verification
REQ-031 SHALL cover a store: req wr=1, addr=5, wdata=0xDEADBEEF -> mem_wr=1 for one cycle with mem_addr=5; resp_valid at N+2 with rdata=0 and err=0.
REQ-032 SHALL cover a load after that store: wr=0, addr=5 -> mem_rd=1 for one cycle; resp_rdata=0xDEADBEEF.
REQ-033 SHALL cover backpressure: resp_ready=0 for 4 cycles -> resp_valid and resp_rdata held stable, req_ready=0 throughout, a single mem strobe.
REQ-034 SHALL cover bounds with the macro defined: addr=4096 -> resp_err=1 at N+1, no mem strobe; without the macro -> resp_err=0 and a strobe is issued.
REQ-035 SHALL cover reset during WRITE: rst_n=0 at the strobe cycle -> mem_wr=0, state IDLE and resp_valid=0 from the next edge.
REQ-036 SHALL cover back-to-back traffic: req_valid held high for 3 requests with resp_ready=1 -> exactly 3 responses in order, with accepts spaced 3 cycles apart.
